// File: rtl/regfile_write_arbiter_if.sv
// Bundles the requester-side handshake and register-file write bus of the write arbiter.
// No logic of its own; widths follow the arbiter parameters.
// Backpressure: Hold from the register file blocks all grants.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
);
    // Requester side: pending writes and their same-cycle acceptance
    logic                       Hold;
    logic [NUM_REQ-1:0]         Req;
    logic [NUM_REQ*ADDR_W-1:0]  ReqAddr;
    logic [NUM_REQ*DATA_W-1:0]  ReqData;
    logic [NUM_REQ-1:0]         Grant;

    // Register-file side: registered single write port
    logic                       RegWrite;
    logic [ADDR_W-1:0]          WriteRegister;
    logic [DATA_W-1:0]          WriteData;
    logic                       Busy;

    // Drives requests, observes grants and the write port
    modport master (
        output Hold, Req, ReqAddr, ReqData,
        input  Grant, RegWrite, WriteRegister, WriteData, Busy
    );

    // The arbiter itself
    modport slave (
        input  Hold, Req, ReqAddr, ReqData,
        output Grant, RegWrite, WriteRegister, WriteData, Busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback requesters.
// Latency: Grant is combinational in the request cycle; write port updates one cycle later.
// Backpressure: Hold (or Reset) forces Grant=0; ungranted requesters keep Req asserted and Busy reports it.
module regfile_write_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    // Round-robin pointer: the requester with highest priority next cycle
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptrNext;

    // Combinational grant result
    logic [NUM_REQ-1:0] grantVec;
    logic [PTR_W-1:0]   grantIdx;
    logic               grantFound;

    // Payload of the granted requester
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selData;

    // Registered write port and status
    logic               regWriteQ;
    logic [ADDR_W-1:0]  writeRegisterQ;
    logic [DATA_W-1:0]  writeDataQ;
    logic               busyQ;

    // Scan requesters starting at ptr, wrapping; the first pending one wins
    always_comb begin
        int idx;
        idx        = 0;
        grantVec   = '0;
        grantIdx   = '0;
        grantFound = 1'b0;
        if (!Reset && !bus.Hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!grantFound && bus.Req[idx]) begin
                    grantVec[idx] = 1'b1;
                    grantIdx      = idx[PTR_W-1:0];
                    grantFound    = 1'b1;
                end
            end
        end
    end

    // Mux the granted requester's address and data onto the write path
    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVec[i]) begin
                selAddr = bus.ReqAddr[i*ADDR_W +: ADDR_W];
                selData = bus.ReqData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Priority moves to the requester just after the winner; unchanged when idle
    always_comb begin
        ptrNext = ptr;
        if (grantFound) begin
            ptrNext = (grantIdx == LAST_IDX) ? '0 : grantIdx + PTR_W'(1);
        end
    end

    // Pointer, write port and busy flag; writes to register 0 load the bus but never strobe
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr            <= '0;
            regWriteQ      <= 1'b0;
            writeRegisterQ <= '0;
            writeDataQ     <= '0;
            busyQ          <= 1'b0;
        end else begin
            ptr       <= ptrNext;
            busyQ     <= |(bus.Req & ~grantVec);
            regWriteQ <= grantFound && (selAddr != '0);
            if (grantFound) begin
                writeRegisterQ <= selAddr;
                writeDataQ     <= selData;
            end
        end
    end

    assign bus.Grant         = grantVec;
    assign bus.RegWrite      = regWriteQ;
    assign bus.WriteRegister = writeRegisterQ;
    assign bus.WriteData     = writeDataQ;
    assign bus.Busy          = busyQ;

    // At most one requester may own the write port in any cycle
    grantOneHot: assert property (@(posedge Clk) $onehot0(grantVec));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with NUM_REQ=2, ADDR_W=2, DATA_W=32.
// Inputs change and Grant is sampled just after the falling edge; registered outputs are sampled at the falling edge.
// Each scenario task carries its own hand-computed expectations.
module tb_regfile_write_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 2;
    localparam int DATA_W  = 32;

    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    regfile_write_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reset for two cycles with all requests dropped; leaves Ptr=0 and ends at a falling edge
    task automatic apply_reset();
        Reset       = 1'b1;
        bus.Hold    = 1'b0;
        bus.Req     = 2'b00;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        bus.Hold    = 1'b0;
        bus.Req     = 2'b11;
        bus.ReqAddr = {2'd3, 2'd1};
        bus.ReqData = {32'h2222_2222, 32'h1111_1111};
        for (int c = 0; c < 2; c++) begin
            @(negedge Clk);
            #1;
            total++;
            if (bus.Grant !== 2'b00) begin bad++; $display("FAIL reset_grant cyc%0d got=%b want=00", c, bus.Grant); end
            total++;
            if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 2'd0 || bus.WriteData !== 32'h0 || bus.Busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs cyc%0d got rw=%b wr=%0d wd=%h busy=%b want 0/0/0/0",
                         c, bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Busy);
            end
        end
        Reset = 1'b0;
        #1;
        total++;
        if (bus.Grant !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b want=01", bus.Grant); end
        @(negedge Clk);
        bus.Req = 2'b00;
        total++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 2'd1 || bus.WriteData !== 32'h1111_1111 || bus.Busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_write got rw=%b wr=%0d wd=%h busy=%b want 1/1/11111111/1",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Busy);
        end
    endtask

    // Ptr=1 here; only requester 0 asks, so the scan wraps to it
    task automatic test_single_write();
        bus.Req     = 2'b01;
        bus.ReqAddr = {2'd0, 2'd2};
        bus.ReqData = {32'h0, 32'hDEAD_BEEF};
        #1;
        total++;
        if (bus.Grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b want=01", bus.Grant); end
        @(negedge Clk);
        bus.Req = 2'b00;
        total++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 2'd2 || bus.WriteData !== 32'hDEAD_BEEF || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL single_write got rw=%b wr=%0d wd=%h busy=%b want 1/2/deadbeef/0",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Busy);
        end
        @(negedge Clk);
        total++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 2'd2 || bus.WriteData !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_idle_hold got rw=%b wr=%0d wd=%h want 0/2/deadbeef",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
    endtask

    // Both requesters held for four cycles alternate starting from Ptr=0
    task automatic test_back_to_back();
        logic [1:0]  expGrant [4];
        logic [1:0]  expReg   [4];
        logic [31:0] expData  [4];
        expGrant = '{2'b01, 2'b10, 2'b01, 2'b10};
        expReg   = '{2'd1, 2'd3, 2'd1, 2'd3};
        expData  = '{32'hA0A0_0001, 32'hB0B0_0003, 32'hA0A0_0001, 32'hB0B0_0003};
        apply_reset();
        bus.Req     = 2'b11;
        bus.ReqAddr = {2'd3, 2'd1};
        bus.ReqData = {32'hB0B0_0003, 32'hA0A0_0001};
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if (bus.Grant !== expGrant[c]) begin bad++; $display("FAIL b2b_grant cyc%0d got=%b want=%b", c, bus.Grant, expGrant[c]); end
            @(negedge Clk);
            if (c == 3) bus.Req = 2'b00;
            total++;
            if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== expReg[c] || bus.WriteData !== expData[c] || bus.Busy !== 1'b1) begin
                bad++;
                $display("FAIL b2b_write cyc%0d got rw=%b wr=%0d wd=%h busy=%b want 1/%0d/%h/1",
                         c, bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Busy, expReg[c], expData[c]);
            end
        end
        @(negedge Clk);
        total++;
        if (bus.RegWrite !== 1'b0 || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got rw=%b busy=%b want 0/0", bus.RegWrite, bus.Busy);
        end
    endtask

    // Write to register 0 is granted and advances Ptr but never strobes RegWrite
    task automatic test_reg_zero();
        bus.Req     = 2'b01;
        bus.ReqAddr = {2'd2, 2'd0};
        bus.ReqData = {32'hC0DE_0002, 32'h0000_0005};
        #1;
        total++;
        if (bus.Grant !== 2'b01) begin bad++; $display("FAIL reg0_grant got=%b want=01", bus.Grant); end
        @(negedge Clk);
        total++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 2'd0 || bus.WriteData !== 32'h0000_0005) begin
            bad++;
            $display("FAIL reg0_suppress got rw=%b wr=%0d wd=%h want 0/0/00000005",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
        bus.Req = 2'b11;
        #1;
        total++;
        if (bus.Grant !== 2'b10) begin bad++; $display("FAIL reg0_ptr_advance got=%b want=10", bus.Grant); end
        @(negedge Clk);
        bus.Req = 2'b00;
        total++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 2'd2 || bus.WriteData !== 32'hC0DE_0002) begin
            bad++;
            $display("FAIL reg0_next_write got rw=%b wr=%0d wd=%h want 1/2/c0de0002",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
    endtask

    // Hold blocks grants for three cycles; Busy reports waiting requesters, Ptr (0) is kept
    task automatic test_hold();
        bus.Hold    = 1'b1;
        bus.Req     = 2'b11;
        bus.ReqAddr = {2'd3, 2'd1};
        bus.ReqData = {32'h3333_3333, 32'h4444_4444};
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (bus.Grant !== 2'b00) begin bad++; $display("FAIL hold_grant cyc%0d got=%b want=00", c, bus.Grant); end
            @(negedge Clk);
            total++;
            if (bus.RegWrite !== 1'b0 || bus.Busy !== 1'b1 || bus.WriteRegister !== 2'd2 || bus.WriteData !== 32'hC0DE_0002) begin
                bad++;
                $display("FAIL hold_outputs cyc%0d got rw=%b busy=%b wr=%0d wd=%h want 0/1/2/c0de0002",
                         c, bus.RegWrite, bus.Busy, bus.WriteRegister, bus.WriteData);
            end
        end
        bus.Hold = 1'b0;
        #1;
        total++;
        if (bus.Grant !== 2'b01) begin bad++; $display("FAIL hold_release_grant got=%b want=01", bus.Grant); end
        @(negedge Clk);
        bus.Req = 2'b00;
        total++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 2'd1 || bus.WriteData !== 32'h4444_4444) begin
            bad++;
            $display("FAIL hold_release_write got rw=%b wr=%0d wd=%h want 1/1/44444444",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData);
        end
    endtask

    // A request withdrawn under Hold never produces a write
    task automatic test_withdraw();
        bus.Hold = 1'b1;
        bus.Req  = 2'b10;
        @(negedge Clk);
        bus.Req  = 2'b00;
        bus.Hold = 1'b0;
        #1;
        total++;
        if (bus.Grant !== 2'b00) begin bad++; $display("FAIL withdraw_grant got=%b want=00", bus.Grant); end
        @(negedge Clk);
        total++;
        if (bus.RegWrite !== 1'b0 || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL withdraw_outputs got rw=%b busy=%b want 0/0", bus.RegWrite, bus.Busy);
        end
    endtask

    // Grant in cycle n, Reset in n+1: exactly one write pulse, then Ptr back to 0
    task automatic test_reset_mid();
        bus.Req     = 2'b10;
        bus.ReqAddr = {2'd3, 2'd0};
        bus.ReqData = {32'h6666_6666, 32'h0};
        #1;
        total++;
        if (bus.Grant !== 2'b10) begin bad++; $display("FAIL rstmid_grant got=%b want=10", bus.Grant); end
        @(negedge Clk);
        Reset   = 1'b1;
        bus.Req = 2'b11;
        #1;
        total++;
        if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 2'd3 || bus.Grant !== 2'b00) begin
            bad++;
            $display("FAIL rstmid_pulse got rw=%b wr=%0d grant=%b want 1/3/00", bus.RegWrite, bus.WriteRegister, bus.Grant);
        end
        @(negedge Clk);
        total++;
        if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 2'd0 || bus.WriteData !== 32'h0 || bus.Busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_cleared got rw=%b wr=%0d wd=%h busy=%b want 0/0/0/0",
                     bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Busy);
        end
        Reset = 1'b0;
        #1;
        total++;
        if (bus.Grant !== 2'b01) begin bad++; $display("FAIL rstmid_ptr_zero got=%b want=01", bus.Grant); end
        @(negedge Clk);
        bus.Req = 2'b00;
        @(negedge Clk);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        Reset       = 1'b1;
        bus.Hold    = 1'b0;
        bus.Req     = '0;
        bus.ReqAddr = '0;
        bus.ReqData = '0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_reg_zero();
        test_hold();
        test_withdraw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
